// File: rtl/coin_manager.sv
// Per-frame coin collision, score and coin mask controller for four coin slots.
// Optional COIN_RESPAWN_EN: per-slot timers bring collected coins back.
module coin_manager #(
    parameter int V_TICK         = 480,
    parameter int RESPAWN_FRAMES = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic [9:0]  char_left,
    input  logic [9:0]  char_right,
    input  logic [9:0]  char_top,
    input  logic [9:0]  char_bottom,
    input  logic        pause,
    input  logic        clear,
    output logic [3:0]  coin_active,
    output logic [7:0]  score_bcd,
    output logic        coin_collected,
    output logic        level_done,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT
    } state_t;

    state_t      state, state_n;
    logic [1:0]  idx, idx_n;
    logic [3:0]  work_mask, mask_n;
    logic [3:0]  active_n;
    logic [7:0]  score_n;
    logic        collected_n;
    logic        done_n;
    logic        tick;
    logic        hit;
    logic [10:0] hstart, hend;

`ifdef COIN_RESPAWN_EN
    logic [3:0][7:0] timer, timer_n;
`endif

    if (RESPAWN_FRAMES < 1 || RESPAWN_FRAMES > 255) begin : g_bad_respawn
        $error("RESPAWN_FRAMES out of range");
    end

    assign tick = (hcount == 11'd0) && (vcount == 11'(V_TICK)) && !pause;
    assign busy = (state != IDLE);

    always_comb begin
        hstart = 11'd102;
        hend   = 11'd132;
        unique case (idx)
            2'd0: begin hstart = 11'd102; hend = 11'd132; end
            2'd1: begin hstart = 11'd154; hend = 11'd184; end
            2'd2: begin hstart = 11'd206; hend = 11'd236; end
            2'd3: begin hstart = 11'd258; hend = 11'd288; end
            default: ;
        endcase
    end

    assign hit = ({1'b0, char_left}   <= hend)
              && ({1'b0, char_right}  >= hstart)
              && ({1'b0, char_bottom} >= 11'd54)
              && ({1'b0, char_top}    <= 11'd86);

    // Two-digit BCD increment, 99 wraps to 00
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd9) r = 8'h00;
            else                r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        mask_n      = work_mask;
        active_n    = coin_active;
        score_n     = score_bcd;
        collected_n = 1'b0;
        done_n      = 1'b0;
`ifdef COIN_RESPAWN_EN
        timer_n     = timer;
`endif
        if (clear) begin
            state_n  = IDLE;
            idx_n    = 2'd0;
            mask_n   = 4'b1111;
            active_n = 4'b1111;
            score_n  = 8'h00;
`ifdef COIN_RESPAWN_EN
            timer_n  = '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (tick) begin
                        state_n = SCAN;
                        idx_n   = 2'd0;
                    end
                end
                SCAN: begin
                    if (work_mask[idx] && hit) begin
                        mask_n[idx] = 1'b0;
                        score_n     = bcd_inc(score_bcd);
                        collected_n = 1'b1;
`ifdef COIN_RESPAWN_EN
                        timer_n[idx] = 8'(RESPAWN_FRAMES);
                    end else if (!work_mask[idx]) begin
                        if (timer[idx] > 8'd1) begin
                            timer_n[idx] = timer[idx] - 8'd1;
                        end else if (timer[idx] == 8'd1) begin
                            mask_n[idx]  = 1'b1;
                            timer_n[idx] = 8'd0;
                        end
`endif
                    end
                    if (idx == 2'd3) state_n = COMMIT;
                    else             idx_n   = idx + 2'd1;
                end
                COMMIT: begin
`ifdef COIN_RESPAWN_EN
                    active_n = work_mask;
`else
                    // An emptied board is refilled before it is ever shown
                    if (work_mask == 4'b0000) begin
                        mask_n   = 4'b1111;
                        active_n = 4'b1111;
                        done_n   = 1'b1;
                    end else begin
                        active_n = work_mask;
                    end
`endif
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            idx            <= 2'd0;
            work_mask      <= 4'b1111;
            coin_active    <= 4'b1111;
            score_bcd      <= 8'h00;
            coin_collected <= 1'b0;
            level_done     <= 1'b0;
`ifdef COIN_RESPAWN_EN
            timer          <= '0;
`endif
        end else begin
            state          <= state_n;
            idx            <= idx_n;
            work_mask      <= mask_n;
            coin_active    <= active_n;
            score_bcd      <= score_n;
            coin_collected <= collected_n;
            level_done     <= done_n;
`ifdef COIN_RESPAWN_EN
            timer          <= timer_n;
`endif
        end
    end

endmodule

// File: tb/tb_coin_manager.sv
// Directed table-driven bench for coin_manager.
// Covers collects, refill or respawn, score wrap, pause, clear, reset.
module tb_coin_manager;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic [9:0]  char_left, char_right, char_top, char_bottom;
    logic        pause, clear;
    logic [3:0]  coin_active;
    logic [7:0]  score_bcd;
    logic        coin_collected, level_done, busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    coin_manager #(
        .V_TICK(480),
        .RESPAWN_FRAMES(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .hcount(hcount),
        .vcount(vcount),
        .char_left(char_left),
        .char_right(char_right),
        .char_top(char_top),
        .char_bottom(char_bottom),
        .pause(pause),
        .clear(clear),
        .coin_active(coin_active),
        .score_bcd(score_bcd),
        .coin_collected(coin_collected),
        .level_done(level_done),
        .busy(busy)
    );

    typedef struct {
        logic [9:0] l, r, t, b;
        logic [3:0] p;
        logic [7:0] sc;
        logic [3:0] act;
        logic       dn;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic set_char(input logic [9:0] l, input logic [9:0] r,
                            input logic [9:0] t, input logic [9:0] b);
        char_left = l; char_right = r; char_top = t; char_bottom = b;
    endtask

    task automatic fire_tick();
        @(negedge clk);
        hcount = 11'd0;
        vcount = 11'd480;
        @(negedge clk);
        hcount = 11'd5;
        vcount = 11'd0;
    endtask

    // One frame: pulses per slot cycle, busy window and committed outputs
    task automatic frame(output logic [3:0] p, output logic bz,
                         output logic [3:0] act, output logic [7:0] sc,
                         output logic dn);
        fire_tick();
        bz = busy;
        p  = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            p[k] = coin_collected;
            bz   = bz & busy;
        end
        @(negedge clk);
        bz  = bz & !busy;
        act = coin_active;
        sc  = score_bcd;
        dn  = level_done;
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        logic [3:0] p, act;
        logic [7:0] sc;
        logic       bz, dn;
        set_char(v.l, v.r, v.t, v.b);
        frame(p, bz, act, sc, dn);
        chk({nm, ".pulses"}, 32'(p), 32'(v.p));
        chk({nm, ".busy"}, 32'(bz), 32'd1);
        chk({nm, ".active"}, 32'(act), 32'(v.act));
        chk({nm, ".score"}, 32'(sc), 32'(v.sc));
        chk({nm, ".done"}, 32'(dn), 32'(v.dn));
    endtask

    vec_t vt[13];
    vec_t vs[5];

    initial begin
        logic [3:0] p, act;
        logic [7:0] sc;
        logic       bz, dn, cl;

        vt[0]  = '{10'd500, 10'd520, 10'd60, 10'd90, 4'h0, 8'h00, 4'hF, 1'b0};
        vt[1]  = '{10'd500, 10'd520, 10'd60, 10'd90, 4'h0, 8'h00, 4'hF, 1'b0};
        vt[2]  = '{10'd500, 10'd520, 10'd60, 10'd90, 4'h0, 8'h00, 4'hF, 1'b0};
        vt[3]  = '{10'd120, 10'd160, 10'd60, 10'd90, 4'h3, 8'h02, 4'hC, 1'b0};
        vt[4]  = '{10'd200, 10'd210, 10'd60, 10'd90, 4'h4, 8'h03, 4'h8, 1'b0};
        vt[5]  = '{10'd250, 10'd300, 10'd0, 10'd53, 4'h0, 8'h03, 4'h8, 1'b0};
        vt[6]  = '{10'd250, 10'd300, 10'd86, 10'd100, 4'h8, 8'h04, 4'hF, 1'b1};
        vt[7]  = '{10'd289, 10'd400, 10'd60, 10'd90, 4'h0, 8'h04, 4'hF, 1'b0};
        vt[8]  = '{10'd0, 10'd101, 10'd60, 10'd90, 4'h0, 8'h04, 4'hF, 1'b0};
        vt[9]  = '{10'd0, 10'd102, 10'd60, 10'd90, 4'h1, 8'h05, 4'hE, 1'b0};
        vt[10] = '{10'd0, 10'd1023, 10'd0, 10'd1023, 4'hE, 8'h08, 4'hF, 1'b1};
        vt[11] = '{10'd0, 10'd1023, 10'd0, 10'd1023, 4'hF, 8'h12, 4'hF, 1'b1};
        vt[12] = '{10'd0, 10'd1023, 10'd87, 10'd100, 4'h0, 8'h12, 4'hF, 1'b0};

        vs[0] = '{10'd200, 10'd210, 10'd60, 10'd90, 4'h4, 8'h01, 4'hB, 1'b0};
        vs[1] = '{10'd200, 10'd210, 10'd60, 10'd90, 4'h0, 8'h01, 4'hB, 1'b0};
        vs[2] = '{10'd200, 10'd210, 10'd60, 10'd90, 4'h0, 8'h01, 4'hB, 1'b0};
        vs[3] = '{10'd200, 10'd210, 10'd60, 10'd90, 4'h0, 8'h01, 4'hF, 1'b0};
        vs[4] = '{10'd200, 10'd210, 10'd60, 10'd90, 4'h4, 8'h02, 4'hB, 1'b0};

        reset  = 1'b0;
        pause  = 1'b0;
        clear  = 1'b0;
        hcount = 11'd5;
        vcount = 11'd0;
        set_char(10'd500, 10'd520, 10'd60, 10'd90);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst.active", 32'(coin_active), 32'hF);
        chk("rst.score", 32'(score_bcd), 32'h00);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.collected", 32'(coin_collected), 32'd0);
        chk("rst.done", 32'(level_done), 32'd0);

`ifdef COIN_RESPAWN_EN
        for (int i = 0; i < 5; i++)
            run_vec($sformatf("resp%0d", i), vs[i]);
`else
        for (int i = 0; i < 13; i++)
            run_vec($sformatf("vec%0d", i), vt[i]);

        set_char(10'd0, 10'd1023, 10'd0, 10'd1023);
        for (int i = 0; i < 21; i++)
            frame(p, bz, act, sc, dn);
        chk("wrap.pre", 32'(sc), 32'h96);
        run_vec("wrap", '{10'd0, 10'd1023, 10'd0, 10'd1023,
                          4'hF, 8'h00, 4'hF, 1'b1});
`endif

        // Pause: tick with character on slot 0 must do nothing
        set_char(10'd0, 10'd110, 10'd60, 10'd90);
        act   = coin_active;
        sc    = score_bcd;
        pause = 1'b1;
        fire_tick();
        bz = 1'b0;
        cl = 1'b0;
        repeat (6) begin
            @(negedge clk);
            bz = bz | busy;
            cl = cl | coin_collected;
        end
        chk("pause.busy", 32'(bz), 32'd0);
        chk("pause.collected", 32'(cl), 32'd0);
        chk("pause.active", 32'(coin_active), 32'(act));
        chk("pause.score", 32'(score_bcd), 32'(sc));
        pause = 1'b0;

        // Clear mid-scan
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        fire_tick();
        @(negedge clk);
        chk("clr.pulse", 32'(coin_collected), 32'd1);
        chk("clr.pre_score", 32'(score_bcd), 32'h01);
        clear = 1'b1;
        @(negedge clk);
        chk("clr.score", 32'(score_bcd), 32'h00);
        chk("clr.active", 32'(coin_active), 32'hF);
        chk("clr.busy", 32'(busy), 32'd0);
        chk("clr.collected", 32'(coin_collected), 32'd0);
        clear = 1'b0;
        run_vec("after_clr", '{10'd0, 10'd110, 10'd60, 10'd90,
                               4'h1, 8'h01, 4'hE, 1'b0});

        // Asynchronous reset mid-scan
        set_char(10'd0, 10'd1023, 10'd0, 10'd1023);
        fire_tick();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("arst.active", 32'(coin_active), 32'hF);
        chk("arst.score", 32'(score_bcd), 32'h00);
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.collected", 32'(coin_collected), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_vec("after_arst", '{10'd500, 10'd520, 10'd60, 10'd90,
                                4'h0, 8'h00, 4'hF, 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
